// File: rtl/pll_lock_sequencer_pkg.sv
// Purpose : shared types and sizing helpers for the PLL lock sequencer.
// Latency : n/a (types, constants and constant functions only).
// Backpressure: none.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // One shared timer serves every state, so it is sized for the largest
  // terminal count. Each terminal value is count-1, so $clog2(max) suffices.
  function automatic int timer_width(input int hold_cycles,
                                     input int timeout_cycles,
                                     input int stable_cycles);
    int m;
    m = hold_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  // Retry counter has to hold 0..max_retries; never narrower than one bit.
  function automatic int retry_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Purpose : bundles the PLL pins, the restart request and the sequencer status.
// Latency : n/a (wires only).
// Backpressure: none; every signal is a level.
// Ports   : pll_locked, sw_restart (to sequencer); pll_rst, sys_rst, ready,
//           fault, state, retry_cnt (from sequencer); lock_loss_cnt only when
//           PLL_LOCK_LOSS_COUNT_EN is defined.
interface pll_lock_sequencer_if #(
  parameter int RETRY_W = 2
);
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               sw_restart;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [STATE_W-1:0] state;
  logic [RETRY_W-1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0]         lock_loss_cnt;

  modport master (
    input  pll_locked, sw_restart,
    output pll_rst, sys_rst, ready, fault, state, retry_cnt, lock_loss_cnt
  );
  modport slave (
    output pll_locked, sw_restart,
    input  pll_rst, sys_rst, ready, fault, state, retry_cnt, lock_loss_cnt
  );
`else
  modport master (
    input  pll_locked, sw_restart,
    output pll_rst, sys_rst, ready, fault, state, retry_cnt
  );
  modport slave (
    output pll_locked, sw_restart,
    input  pll_rst, sys_rst, ready, fault, state, retry_cnt
  );
`endif

endinterface

// File: rtl/pll_lock_sequencer_sync.sv
// Purpose : STAGES-deep flip-flop synchronizer for the asynchronous PLL lock pin.
// Latency : STAGES clk edges from d to q.
// Backpressure: none.
// Ports   : clk, rst (sync, active-high, clears chain to 0), d (async in), q.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Purpose : PLL power-up/recovery sequencer: hold PLL reset, wait for lock with
//           timeout, require stable lock, then release sys_rst; retry, then fault.
// Latency : ready/sys_rst change SYNC_STAGES+STABLE_CYCLES edges after lock is first sampled.
// Backpressure: none; sw_restart is a single-cycle request with top priority.
// Ports   : refclk, rst (sync active-high), bus (pll_lock_sequencer_if.master).
// Option  : PLL_LOCK_LOSS_COUNT_EN adds bus.lock_loss_cnt (saturating RUN lock losses).
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  localparam int TW = timer_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int RW = retry_width(MAX_RETRIES);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lock_s;
  logic          lost_in_run;
  logic          pll_rst_q, sys_rst_q, ready_q, fault_q;

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    lost_in_run = 1'b0;
    if (bus.sw_restart) begin
      state_d = ST_HOLD;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            timer_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          // A dropout here only restarts the lock wait; it is not a failed attempt.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d     = ST_HOLD;
            timer_d     = '0;
            lost_in_run = 1'b1;
          end
        end
        ST_FAULT: begin
          // Sticky until rst or sw_restart.
        end
        default: begin
          state_d = ST_HOLD;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      timer_q   <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == ST_HOLD) || (state_d == ST_FAULT);
      sys_rst_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;

  // Survives sw_restart on purpose: it is a field-diagnostic history.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lost_in_run && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`else
  logic unused_lost_in_run;
  assign unused_lost_in_run = lost_in_run;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose : self-checking bench for pll_lock_sequencer (directed scenarios + random phase).
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int H  = 4;
  localparam int T  = 20;
  localparam int S  = 8;
  localparam int R  = 2;
  localparam int SS = 2;
  localparam int RW = retry_width(R);

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  always #5 refclk = ~refclk;

  pll_lock_sequencer_if #(.RETRY_W(RW)) bus();

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (H),
    .LOCK_TIMEOUT_CYCLES (T),
    .STABLE_CYCLES       (S),
    .MAX_RETRIES         (R),
    .SYNC_STAGES         (SS)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state number, cycles spent in it, failed attempts,
  // lock-loss count; the synchronizer is just a delay line of samples.
  int m_state   = 0;
  int m_elapsed = 0;
  int m_retry   = 0;
  int m_llc     = 0;
  bit hist[$];
  bit model_on  = 1'b0;

  function automatic void go(input int s);
    m_state   = s;
    m_elapsed = 0;
  endfunction

  function automatic void model_reset();
    go(0);
    m_retry = 0;
    m_llc   = 0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(1'b0);
  endfunction

  function automatic void step(input bit ls, input bit swr);
    if (swr) begin
      go(0);
      m_retry = 0;
      return;
    end
    case (m_state)
      0: if (m_elapsed + 1 == H) go(1); else m_elapsed++;
      1: begin
        if (ls) go(2);
        else if (m_elapsed + 1 == T) begin
          if (m_retry < R) begin m_retry++; go(0); end
          else go(4);
        end else m_elapsed++;
      end
      2: begin
        if (!ls) go(1);
        else if (m_elapsed + 1 == S) begin go(3); m_retry = 0; end
        else m_elapsed++;
      end
      3: if (!ls) begin go(0); if (m_llc < 255) m_llc++; end
      default: ;
    endcase
  endfunction

  always @(posedge refclk) begin
    bit ls;
    if (rst) begin
      model_reset();
      model_on = 1'b1;
    end else if (model_on) begin
      ls = hist.pop_front();
      hist.push_back(bus.pll_locked);
      step(ls, bus.sw_restart);
    end
  end

  always @(negedge refclk) begin
    if (model_on) begin
      chk("state",     bus.state,     m_state);
      chk("pll_rst",   bus.pll_rst,   (m_state == 0) || (m_state == 4));
      chk("sys_rst",   bus.sys_rst,   m_state != 3);
      chk("ready",     bus.ready,     m_state == 3);
      chk("fault",     bus.fault,     m_state == 4);
      chk("retry_cnt", bus.retry_cnt, m_retry);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("lock_loss_cnt", bus.lock_loss_cnt, m_llc);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.state != s && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, bus.state, s);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"},   bus.state,     0);
    chk({pfx, "_pll_rst"}, bus.pll_rst,   1);
    chk({pfx, "_sys_rst"}, bus.sys_rst,   1);
    chk({pfx, "_ready"},   bus.ready,     0);
    chk({pfx, "_fault"},   bus.fault,     0);
    chk({pfx, "_retry"},   bus.retry_cnt, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    bus.pll_locked = 1'b0;
    bus.sw_restart = 1'b0;
    rst = 1'b1;
    cyc(3);
    chk_reset_vals("por");
    rst = 1'b0;

    // Clean start: pll_rst high for 4 edges, then WAIT_LOCK.
    cyc(3);
    chk("hold_pll_rst_hi", bus.pll_rst, 1);
    cyc(1);
    chk("hold_pll_rst_lo", bus.pll_rst, 0);
    chk("hold_to_wait", bus.state, 1);
    cyc(1);
    bus.pll_locked = 1'b1;
    cyc(1);  // first edge that samples the lock high
    n = 0;
    while (!bus.ready && n < 40) begin cyc(1); n++; end
    chk("release_latency", n, SS + S);
    chk("release_sys_rst", bus.sys_rst, 0);
    chk("release_retry", bus.retry_cnt, 0);

    // Lock loss in RUN.
    cyc(3);
    bus.pll_locked = 1'b0;
    cyc(1);
    n = 0;
    while (!bus.sys_rst && n < 20) begin cyc(1); n++; end
    chk("loss_latency", n, SS);
    chk("loss_ready", bus.ready, 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk("loss_count", bus.lock_loss_cnt, 1);
`endif
    n = 0;
    while (bus.pll_rst && n < 20) begin n++; cyc(1); end
    chk("loss_hold_len", n, H);

    // Lock never arrives: two retries, then FAULT.
    n = 0;
    while (!bus.fault && n < 300) begin cyc(1); n++; end
    chk("fault_latency", n, (R + 1) * T + R * H);
    chk("fault_retry", bus.retry_cnt, R);
    chk("fault_pll_rst", bus.pll_rst, 1);
    cyc(10);
    chk("fault_sticky", bus.state, 4);
    bus.sw_restart = 1'b1;
    cyc(1);
    bus.sw_restart = 1'b0;
    chk("restart_state", bus.state, 0);
    chk("restart_retry", bus.retry_cnt, 0);
    chk("restart_fault", bus.fault, 0);

    // sw_restart on the final timeout edge beats both retry and FAULT.
    n = 0;
    while (!(bus.retry_cnt == R && bus.state == 1) && n < 200) begin cyc(1); n++; end
    chk("last_attempt_reached", bus.retry_cnt, R);
    cyc(T - 1);
    bus.sw_restart = 1'b1;
    cyc(1);
    bus.sw_restart = 1'b0;
    chk("simul_state", bus.state, 0);
    chk("simul_retry", bus.retry_cnt, 0);
    chk("simul_fault", bus.fault, 0);

    // One-cycle glitch during STABLE: back to WAIT_LOCK, no retry, full re-count.
    bus.pll_locked = 1'b1;
    wait_state(2, 100, "glitch_reach_stable");
    cyc(2);
    bus.pll_locked = 1'b0;
    cyc(1);
    bus.pll_locked = 1'b1;
    wait_state(1, 10, "glitch_back_to_wait");
    chk("glitch_retry", bus.retry_cnt, 0);
    wait_state(2, 10, "glitch_restable");
    n = 0;
    while (bus.state != 3 && n < 40) begin cyc(1); n++; end
    chk("glitch_stable_len", n, S);

    // rst in the middle of STABLE.
    bus.sw_restart = 1'b1;
    cyc(1);
    bus.sw_restart = 1'b0;
    wait_state(2, 50, "midrst_reach_stable");
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_reset_vals("midrst");
    wait_state(3, 60, "midrst_resequence");

    // Random phase, checked cycle by cycle against the model.
    for (int seg = 0; seg < 150; seg++) begin
      len = $urandom_range(1, 45);
      bus.pll_locked = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++) begin
        bus.sw_restart = ($urandom_range(0, 199) == 0);
        rst            = ($urandom_range(0, 399) == 0);
        cyc(1);
      end
    end
    bus.sw_restart = 1'b0;
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Power-up and recovery sequencer for the fabric PLL. It holds the PLL in reset for a fixed time, then waits for a lock with a timeout and requires the lock to stay stable before releasing the downstream system reset. On lock loss it re-sequences the PLL, and after bounded retries it latches a fault. It sits between the board reference clock/reset and the PLL's rst/locked pins, and feeds the reset tree of the LED-sweep logic.

Parameters:
- RST_HOLD_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: maximum cycles in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (>=1).
- MAX_RETRIES, 3: failed attempts retried before FAULT (>=0).
- SYNC_STAGES, 2: flip-flop synchronizer depth on pll_locked (>=2).

Ports:
- refclk, in, 1: board reference clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL locked, asynchronous to refclk.
- sw_restart, in, 1: single-cycle request to restart the sequence from any state.
- pll_rst, out, 1: reset to the PLL, active-high.
- sys_rst, out, 1: downstream reset, active-high, refclk domain.
- ready, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- state, out, 3: current state encoding.
- retry_cnt, out, $clog2(MAX_RETRIES+1) with a minimum of 1: failed attempts in the current sequence.

Behaviour:
- Interface: one clock, refclk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: pll_rst=1, sys_rst=1, ready=0, fault=0, state=HOLD (0), retry_cnt=0. The synchronizer chain and all counters also clear.
- pll_locked passes through a SYNC_STAGES flip-flop chain to give lock_s. No other logic samples pll_locked directly.
- State encoding: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- HOLD: pll_rst=1, sys_rst=1. After exactly RST_HOLD_CYCLES cycles go to WAIT_LOCK and clear the timer.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - lock_s=1: go to STABLE and clear the timer.
  - Otherwise, when the timer reaches LOCK_TIMEOUT_CYCLES-1:
    - If retry_cnt<MAX_RETRIES, increment retry_cnt and go to HOLD.
    - Else go to FAULT.
- STABLE: pll_rst=0, sys_rst=1.
  - lock_s=0: go to WAIT_LOCK, clearing the timer. This is not counted as a retry.
  - After STABLE_CYCLES consecutive cycles with lock_s=1: go to RUN.
- RUN: pll_rst=0, sys_rst=0, ready=1. retry_cnt clears on entry.
  - lock_s=0: go to HOLD. On that same edge sys_rst=1 and ready=0.
- FAULT: pll_rst=1, sys_rst=1, fault=1. Sticky; left only via rst or sw_restart.
- sw_restart=1 in any state: go to HOLD and clear retry_cnt and all timers. It takes priority over every other transition in that cycle.
- rst asserted mid-sequence: all reset values apply on the next edge, whatever the state.
- Release latency: from the first edge at which pll_locked is sampled high while in WAIT_LOCK, ready and sys_rst change after exactly SYNC_STAGES+STABLE_CYCLES edges, provided lock holds.
- Timers are sized $clog2 of the largest cycle parameter and do not wrap; each is cleared on every state entry.
- sys_rst is in the refclk domain. Consumers in PLL-output domains re-synchronize it.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined: adds output lock_loss_cnt [7:0].
  - Increments on every RUN->HOLD transition caused by lock_s=0.
  - Saturates at 255.
  - Clears only on rst, not on sw_restart.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum type and its 3-bit encoding;
  - the state width constant;
  - a function returning the counter width from the parameters.
- One natural sub-module: pll_lock_sync, a SYNC_STAGES-deep synchronizer, reset to 0 by rst.
- The FSM, timers and retry logic stay in the top module.

Test Plan:
All scenarios use RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean start: release rst and raise pll_locked at cycle 6. Expect pll_rst high for cycles 1-4 and low from cycle 5; state reaches WAIT_LOCK. ready=1 and sys_rst=0 exactly 10 edges after the first high sample; retry_cnt=0.
- Lock never arrives: keep pll_locked low. Expect retry_cnt to step 1 then 2, each step followed by a 4-cycle pll_rst pulse. After the third 20-cycle timeout, state=FAULT, fault=1, pll_rst=1. It stays there until sw_restart, which returns state to HOLD with retry_cnt=0.
- Lock glitch: drop pll_locked for 1 cycle during STABLE. Expect a return to WAIT_LOCK with no retry increment, then a full 8 stable cycles before RUN.
- Lock loss in RUN: drop pll_locked. Expect sys_rst=1 and ready=0 exactly 2 edges after the drop (synchronizer latency), then a 4-cycle pll_rst pulse and a normal re-sequence. With the macro defined, lock_loss_cnt increments by 1.
- Simultaneous events: assert sw_restart in the same cycle the timeout expires. Expect state HOLD with retry_cnt=0, not a retry increment and not FAULT.
- Reset mid-STABLE: assert rst for 1 cycle. Expect every output at its reset value on the next edge, then a fresh sequence.
